// File: rtl/token_table_pkg.sv
// Shared types and width helpers for the token table arbiter and its round-robin sub-block.
package token_table_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int SIZE_DEF   = 64;
  localparam int NREQ_DEF   = 4;
  localparam int MAX_WR_DEF = 4;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int aw_of(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Requester id width never collapses to zero bits, even for a single requester.
  function automatic int id_w_of(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int streak_w_of(input int max_wr);
    return (max_wr > 0) ? $clog2(max_wr + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NREQ requests starting at ptr; purely combinational, one-hot grant.
module rr_arbiter
  import token_table_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IW   = id_w_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/token_table_arbiter.sv
// Sole master of a dual-read/single-write table: one op per cycle (clear sweep > write > RR read),
// read data returned one cycle after the grant; writes yield to pending reads after MAX_WR in a row.
module token_table_arbiter
  import token_table_pkg::*;
#(
  parameter int  WIDTH  = WIDTH_DEF,
  parameter int  SIZE   = SIZE_DEF,
  parameter int  NREQ   = NREQ_DEF,
  parameter int  MAX_WR = MAX_WR_DEF,
  localparam int AW     = aw_of(SIZE),
  localparam int IW     = id_w_of(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_idx_a,
  input  logic [NREQ*AW-1:0] req_idx_b,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [WIDTH-1:0]   rsp_rd1,
  output logic [WIDTH-1:0]   rsp_rd2,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic [WIDTH-1:0]   tbl_a,
  output logic [WIDTH-1:0]   tbl_b,
  output logic [WIDTH-1:0]   tbl_data,
  output logic               tbl_en,
  input  logic [WIDTH-1:0]   tbl_rd1,
  input  logic [WIDTH-1:0]   tbl_rd2
);

  localparam int SW = streak_w_of(MAX_WR);

  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_size_chk
    $error("token_table_arbiter: SIZE must be a power of two");
  end
  if (NREQ < 1) begin : g_nreq_chk
    $error("token_table_arbiter: NREQ must be at least 1");
  end
  if (MAX_WR < 1) begin : g_maxwr_chk
    $error("token_table_arbiter: MAX_WR must be at least 1");
  end
  if (WIDTH < AW) begin : g_width_chk
    $error("token_table_arbiter: WIDTH must hold a table index");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            any_req;
  logic [SW-1:0]   wr_streak;
  logic [AW-1:0]   clr_cnt;
  logic            do_wr, do_rd, go_clr, streak_full;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (any_req)
  );

  assign streak_full = (wr_streak == SW'(MAX_WR));

  // All grants and table drives are forced quiet while reset is held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    wr_ready  = 1'b0;
    clr_busy  = 1'b0;
    tbl_en    = 1'b0;
    tbl_a     = '0;
    tbl_b     = '0;
    tbl_data  = '0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    go_clr    = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (clr_start) begin
            go_clr  = 1'b1;
            state_d = CLEAR;
          end else if (wr_valid && !(streak_full && any_req)) begin
            do_wr    = 1'b1;
            wr_ready = 1'b1;
            tbl_en   = 1'b1;
            tbl_a    = WIDTH'(wr_addr);
            tbl_data = wr_data;
          end else if (any_req) begin
            do_rd     = 1'b1;
            req_ready = gnt;
            tbl_a     = WIDTH'(req_idx_a[int'(gnt_idx)*AW +: AW]);
            tbl_b     = WIDTH'(req_idx_b[int'(gnt_idx)*AW +: AW]);
          end
        end
        CLEAR: begin
          clr_busy = 1'b1;
          tbl_en   = 1'b1;
          tbl_a    = WIDTH'(clr_cnt);
          if (clr_cnt == AW'(SIZE - 1)) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      rr_ptr    <= '0;
      wr_streak <= '0;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rd1   <= '0;
      rsp_rd2   <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= do_rd;
      if (do_rd) begin
        rsp_id    <= gnt_idx;
        rsp_rd1   <= tbl_rd1;
        rsp_rd2   <= tbl_rd2;
        rr_ptr    <= IW'((int'(gnt_idx) + 1) % NREQ);
        wr_streak <= '0;
      end else if (do_wr) begin
        // The streak only matters while a reader is being held off.
        if (!any_req) begin
          wr_streak <= '0;
        end else if (!streak_full) begin
          wr_streak <= wr_streak + SW'(1);
        end
      end else if (!any_req) begin
        wr_streak <= '0;
      end
      if (go_clr) begin
        clr_cnt <= '0;
      end else if (state_q == CLEAR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end
  end

endmodule
